// File: rtl/aes_round_sequencer_pkg.sv
// Shared AES-128 definitions for the iterative round sequencer.
// Holds the opaque data/key/state types, the sequencer FSM encoding,
// the round count, the S-box table and small byte helpers (S-box lookup,
// GF(2^8) xtime, round constant).
package aes_round_sequencer_pkg;

  typedef logic [127:0] t_opaque_AESData;
  typedef logic [127:0] t_opaque_AESKey;
  typedef logic [127:0] t_opaque_AESState;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } t_aes_seq_state;

  localparam logic [3:0] AES_NR = 4'd10;

  localparam logic [7:0] AES_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] aes_sbox(input logic [7:0] b);
    return AES_SBOX[b];
  endfunction

  function automatic logic [7:0] aes_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Round constant table for rounds 1..10; any other index yields 0.
  function automatic logic [7:0] aes_rcon(input logic [3:0] round);
    logic [7:0] rc;
    case (round)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/addRoundKey.sv
// addRoundKey: XOR of the state with a 128-bit round key.
// Ports: state_i (state in), key_i (round key), state_o (result).
module addRoundKey
  import aes_round_sequencer_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] key_i,
  output logic [127:0] state_o
);

  assign state_o = state_i ^ key_i;

endmodule

// File: rtl/mixColumns.sv
// mixColumns: multiplies each state column by the fixed AES polynomial
// {03}x^3 + {01}x^2 + {01}x + {02} over GF(2^8).
// Ports: state_i (state in), state_o (mixed state).
module mixColumns
  import aes_round_sequencer_pkg::*;
(
  input  logic [127:0] state_i,
  output logic [127:0] state_o
);

  logic [7:0] a0, a1, a2, a3;

  always_comb begin
    state_o = '0;
    a0 = '0;
    a1 = '0;
    a2 = '0;
    a3 = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = state_i[127 - 32*c      -: 8];
      a1 = state_i[127 - 32*c - 8  -: 8];
      a2 = state_i[127 - 32*c - 16 -: 8];
      a3 = state_i[127 - 32*c - 24 -: 8];
      state_o[127 - 32*c      -: 8] = aes_xtime(a0) ^ aes_xtime(a1) ^ a1 ^ a2 ^ a3;
      state_o[127 - 32*c - 8  -: 8] = a0 ^ aes_xtime(a1) ^ aes_xtime(a2) ^ a2 ^ a3;
      state_o[127 - 32*c - 16 -: 8] = a0 ^ a1 ^ aes_xtime(a2) ^ aes_xtime(a3) ^ a3;
      state_o[127 - 32*c - 24 -: 8] = aes_xtime(a0) ^ a0 ^ a1 ^ a2 ^ aes_xtime(a3);
    end
  end

endmodule

// File: rtl/round_key_step.sv
// round_key_step: derives the next AES-128 round key from the previous one.
// temp = SubWord(RotWord(w3)) ^ {rcon,000000}; then w0..w3 form an XOR chain.
// Ports: key_i (previous round key), rcon_i (round constant),
//        key_o (next round key).
module round_key_step
  import aes_round_sequencer_pkg::*;
(
  input  logic [127:0] key_i,
  input  logic [7:0]   rcon_i,
  output logic [127:0] key_o
);

  logic [31:0] rot_w;
  logic [31:0] sub_w;
  logic [31:0] temp_w;
  logic [31:0] n0, n1, n2, n3;

  always_comb begin
    rot_w  = {key_i[23:0], key_i[31:24]};
    sub_w  = {aes_sbox(rot_w[31:24]), aes_sbox(rot_w[23:16]),
              aes_sbox(rot_w[15:8]),  aes_sbox(rot_w[7:0])};
    temp_w = sub_w ^ {rcon_i, 24'h000000};
    n0     = key_i[127:96] ^ temp_w;
    n1     = key_i[95:64]  ^ n0;
    n2     = key_i[63:32]  ^ n1;
    n3     = key_i[31:0]   ^ n2;
    key_o  = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/shiftRows.sv
// shiftRows: cyclic left shift of state row r by r bytes.
// Byte n of the block (n=0 in bits 127:120) sits at row n%4, column n/4.
// Ports: state_i (state in), state_o (shifted state).
module shiftRows
  import aes_round_sequencer_pkg::*;
(
  input  logic [127:0] state_i,
  output logic [127:0] state_o
);

  always_comb begin
    state_o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        state_o[127 - 8*(r + 4*c) -: 8] = state_i[127 - 8*(r + 4*((c + r) % 4)) -: 8];
      end
    end
  end

endmodule

// File: rtl/subBytes.sv
// subBytes: byte-wise S-box substitution of the 128-bit AES state.
// Ports: state_i (state in), state_o (substituted state).
module subBytes
  import aes_round_sequencer_pkg::*;
(
  input  logic [127:0] state_i,
  output logic [127:0] state_o
);

  always_comb begin
    state_o = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      state_o[8*i +: 8] = aes_sbox(state_i[8*i +: 8]);
    end
  end

endmodule

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: iterative AES-128 encryption, one round per clock.
// A block accepted on the input handshake is XORed with the key (round 0),
// then ten RUN cycles apply one round each while the next round key is
// derived on the fly. The ciphertext is presented in DONE until the sink
// takes it; a new block may be accepted in that same cycle.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   data, key, in_valid input block/key and valid; in_ready accepts
//   o, o_valid, o_ready ciphertext, valid, sink ready
//   busy                high while rounds are being computed
module aes_round_sequencer
  import aes_round_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  t_opaque_AESData data,
  input  t_opaque_AESKey  key,
  input  logic            in_valid,
  output logic            in_ready,
  output t_opaque_AESData o,
  output logic            o_valid,
  input  logic            o_ready,
  output logic            busy
);

  t_aes_seq_state   fsm_q, fsm_d;
  t_opaque_AESState state_q, state_d;
  t_opaque_AESKey   rkey_q, rkey_d;
  logic [3:0]       round_q, round_d;
  logic             o_valid_q, o_valid_d;
  logic             busy_q, busy_d;

  logic             accept;
  logic [7:0]       rcon;
  t_opaque_AESState sb_out, sr_out, mc_out, round_out;
  t_opaque_AESState ark_state, ark_out;
  t_opaque_AESKey   ark_key, next_key;

  assign in_ready = (fsm_q == IDLE) || ((fsm_q == DONE) && o_ready);
  assign accept   = in_valid && in_ready;

  assign rcon = aes_rcon(round_q);

  subBytes u_sub_bytes (
    .state_i (state_q),
    .state_o (sb_out)
  );

  shiftRows u_shift_rows (
    .state_i (sb_out),
    .state_o (sr_out)
  );

  mixColumns u_mix_columns (
    .state_i (sr_out),
    .state_o (mc_out)
  );

  // Final round skips mixColumns.
  assign round_out = (round_q == AES_NR) ? sr_out : mc_out;

  round_key_step u_round_key_step (
    .key_i  (rkey_q),
    .rcon_i (rcon),
    .key_o  (next_key)
  );

  // The single addRoundKey serves both the round-0 whitening on accept
  // (data ^ key) and the per-round key addition in RUN; accept never
  // happens in RUN, so the operand mux is keyed on the state alone.
  assign ark_state = (fsm_q == RUN) ? round_out : data;
  assign ark_key   = (fsm_q == RUN) ? next_key  : key;

  addRoundKey u_add_round_key (
    .state_i (ark_state),
    .key_i   (ark_key),
    .state_o (ark_out)
  );

  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    rkey_d    = rkey_q;
    round_d   = round_q;
    o_valid_d = o_valid_q;
    busy_d    = busy_q;

    unique case (fsm_q)
      IDLE: begin
        if (accept) begin
          state_d   = ark_out;
          rkey_d    = key;
          round_d   = 4'd1;
          busy_d    = 1'b1;
          fsm_d     = RUN;
        end
      end
      RUN: begin
        state_d = ark_out;
        rkey_d  = next_key;
        round_d = round_q + 4'd1;
        if (round_q == AES_NR) begin
          fsm_d     = DONE;
          o_valid_d = 1'b1;
          busy_d    = 1'b0;
        end
      end
      DONE: begin
        if (o_ready) begin
          o_valid_d = 1'b0;
          fsm_d     = IDLE;
          if (accept) begin
            state_d = ark_out;
            rkey_d  = key;
            round_d = 4'd1;
            busy_d  = 1'b1;
            fsm_d   = RUN;
          end
        end
      end
      default: begin
        fsm_d     = IDLE;
        o_valid_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= IDLE;
      state_q   <= '0;
      rkey_q    <= '0;
      round_q   <= '0;
      o_valid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      state_q   <= state_d;
      rkey_q    <= rkey_d;
      round_q   <= round_d;
      o_valid_q <= o_valid_d;
      busy_q    <= busy_d;
    end
  end

  assign o       = state_q;
  assign o_valid = o_valid_q;
  assign busy    = busy_q;

endmodule
